// File: rtl/npn_func_pkg.sv
// Shared types and helpers for the NPN function pipeline: FSM states,
// the reset truth table and permutation-field utilities.
package npn_func_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Widest supported configuration (N_IN = 6 -> 3-bit permutation fields).
  localparam int N_IN_MAX   = 6;
  localparam int IW_MAX     = 3;
  localparam int PERM_MAX_W = N_IN_MAX * IW_MAX;

  // Truth table loaded at reset; bit k = f(idx = k).
  localparam logic [15:0] DEFAULT_TT = 16'h0691;

  // Permutation field width for a given input count (max(1, clog2(n))).
  function automatic int idx_w(input int n_in);
    if (n_in <= 2)      return 1;
    else if (n_in <= 4) return 2;
    else                return 3;
  endfunction

  // True when every field names a distinct source index below n_in.
  function automatic logic perm_is_bijective(input logic [PERM_MAX_W-1:0] perm,
                                             input int                    n_in);
    int                iw;
    logic [7:0]        seen;
    logic              ok;
    logic [IW_MAX-1:0] idx;
    iw   = idx_w(n_in);
    seen = '0;
    ok   = 1'b1;
    for (int i = 0; i < N_IN_MAX; i++) begin
      if (i < n_in) begin
        idx = IW_MAX'((perm >> (i * iw)) & PERM_MAX_W'((1 << iw) - 1));
        if (int'(idx) >= n_in) ok = 1'b0;
        else if (seen[idx])    ok = 1'b0;
        else                   seen[idx] = 1'b1;
      end
    end
    return ok;
  endfunction

  // Permutation word with field i = i.
  function automatic logic [PERM_MAX_W-1:0] identity_perm(input int n_in);
    logic [PERM_MAX_W-1:0] p;
    int                    iw;
    iw = idx_w(n_in);
    p  = '0;
    for (int i = 0; i < N_IN_MAX; i++) begin
      if (i < n_in) p = p | (PERM_MAX_W'(i) << (i * iw));
    end
    return p;
  endfunction

endpackage

// File: rtl/npn_func_pipe_xform.sv
// Combinational NPN input transform: negate the input vector, then gather
// each output bit from the source position named by its permutation field.
module npn_xform
  import npn_func_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IW   = 2
) (
  input  logic [N_IN-1:0]    x,
  input  logic [N_IN-1:0]    neg_in,
  input  logic [N_IN*IW-1:0] perm,
  output logic [N_IN-1:0]    t
);

  logic [N_IN-1:0] u;

  assign u = x ^ neg_in;

  // Gather t[i] = u[perm_i]; fields are validated before they are loaded.
  always_comb begin
    t = '0;
    for (int i = 0; i < N_IN; i++) begin
      t[i] = u[perm[i*IW +: IW]];
    end
  end

endmodule

// File: rtl/npn_func_pipe.sv
// Two-stage streaming evaluator of one truth-table function under a loadable
// NPN transform. Configuration changes drain the pipeline first, so every
// vector is evaluated entirely under the config active when it was accepted.
module npn_func_pipe #(
  parameter int              N_IN       = 4,
  parameter int              TT_W       = 2**N_IN,
  parameter int              IW         = (N_IN > 2) ? $clog2(N_IN) : 1,
  parameter logic [TT_W-1:0] DEFAULT_TT = TT_W'(npn_func_pkg::DEFAULT_TT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_y,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TT_W-1:0]    cfg_tt,
  input  logic [N_IN-1:0]    cfg_neg_in,
  input  logic [N_IN*IW-1:0] cfg_perm,
  input  logic               cfg_neg_out,
  output logic               cfg_err
);

  import npn_func_pkg::*;

  localparam int            PW      = N_IN * IW;
  localparam logic [PW-1:0] ID_PERM = PW'(identity_perm(N_IN));

  state_t            state_q, state_d;

  logic [TT_W-1:0]   tt_q;
  logic [N_IN-1:0]   neg_in_q;
  logic [PW-1:0]     perm_q;
  logic              neg_out_q;

  logic [N_IN-1:0]   t_p0;
  logic [N_IN-1:0]   t_p1;
  logic              vld_p1;
  logic              vld_p2;
  logic              y_p2;

  logic              s1_adv;
  logic              s2_adv;
  logic              perm_ok;
  logic              cfg_load;

  assign s2_adv    = !vld_p2 || out_ready;
  assign s1_adv    = !vld_p1 || s2_adv;
  assign in_ready  = (state_q == ST_RUN) && !cfg_valid && s1_adv;
  assign perm_ok   = perm_is_bijective(PERM_MAX_W'(cfg_perm), N_IN);
  assign out_valid = vld_p2;
  assign out_y     = y_p2;

  // Stage 0 -> 1: negate and permute the incoming vector.
  npn_xform #(.N_IN(N_IN), .IW(IW)) u_xform (
    .x      (in_x),
    .neg_in (neg_in_q),
    .perm   (perm_q),
    .t      (t_p0)
  );

  // Next-state and config handshake: RUN -> DRAIN on request, LOAD once empty.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    cfg_load  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!vld_p1 && !vld_p2) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d   = ST_RUN;
        cfg_ready = cfg_valid;
        cfg_err   = cfg_valid && !perm_ok;
        cfg_load  = cfg_valid && perm_ok;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Active configuration; replaced only by a legal request in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q      <= DEFAULT_TT;
      neg_in_q  <= '0;
      perm_q    <= ID_PERM;
      neg_out_q <= 1'b0;
    end else if (cfg_load) begin
      tt_q      <= cfg_tt;
      neg_in_q  <= cfg_neg_in;
      perm_q    <= cfg_perm;
      neg_out_q <= cfg_neg_out;
    end
  end

  // Stage 1 occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid && in_ready;
  end

  // Stage 1 data: transformed index, captured only on accept.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid && in_ready) t_p1 <= t_p0;
  end

  // Stage 1 -> 2: truth-table lookup and output negation; held under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      y_p2   <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) y_p2 <= tt_q[t_p1] ^ neg_out_q;
    end
  end

endmodule

// File: tb/tb_npn_func_pipe.sv
// Directed bench for npn_func_pipe: table-driven vectors across several
// configurations, plus backpressure and reset-during-drain sequences.
module tb_npn_func_pipe;

  localparam int N_IN = 4;
  localparam int IW   = 2;
  localparam int TT_W = 16;

  typedef struct {
    logic [15:0] tt;
    logic [3:0]  neg_in;
    logic [7:0]  perm;
    logic        neg_out;
    logic        err;
  } cfg_t;

  typedef struct {
    int         cfg_id;
    logic [3:0] x;
    logic       y;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N_IN-1:0]     in_x;
  logic                out_valid;
  logic                out_ready;
  logic                out_y;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [TT_W-1:0]     cfg_tt;
  logic [N_IN-1:0]     cfg_neg_in;
  logic [N_IN*IW-1:0]  cfg_perm;
  logic                cfg_neg_out;
  logic                cfg_err;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic lat_chk = 1'b1;
  logic sb_y[$];
  int   sb_c[$];

  cfg_t       cfgs[6];
  vec_t       vecs[14];
  logic [3:0] bp_x[8];
  logic       bp_y[8];

  npn_func_pipe #(.N_IN(N_IN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_tt      (cfg_tt),
    .cfg_neg_in  (cfg_neg_in),
    .cfg_perm    (cfg_perm),
    .cfg_neg_out (cfg_neg_out),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one vector until accepted; optionally queue its expected result.
  task automatic send(input logic [3:0] x, input logic y, input logic push);
    logic got;
    got      = 1'b0;
    in_x     = x;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (push) begin
          sb_y.push_back(y);
          sb_c.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check1("send_accepted", got, 1'b1);
  endtask

  // Wait until every queued result has been delivered.
  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb_y.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkn(name, sb_y.size(), 0);
  endtask

  // Issue a configuration request and follow it through DRAIN and LOAD.
  task automatic do_cfg(input cfg_t c);
    logic got;
    got         = 1'b0;
    cfg_tt      = c.tt;
    cfg_neg_in  = c.neg_in;
    cfg_perm    = c.perm;
    cfg_neg_out = c.neg_out;
    cfg_valid   = 1'b1;
    @(negedge clk);
    check1("cfg_blocks_in_ready", in_ready, 1'b0);
    check1("cfg_ready_not_early", cfg_ready, 1'b0);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1'b1;
        check1("cfg_err", cfg_err, c.err);
        check1("drained_at_load", out_valid, 1'b0);
      end
    end
    check1("cfg_ready_seen", got, 1'b1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check1("cfg_err_one_cycle", cfg_err, 1'b0);
    check1("cfg_ready_one_cycle", cfg_ready, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: in-order scoreboard, latency, and hold-under-stall.
  initial begin : monitor
    logic hold;
    logic hold_y;
    logic y;
    int   c;
    hold   = 1'b0;
    hold_y = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check1("stall_valid_held", out_valid, 1'b1);
          check1("stall_y_stable", out_y, hold_y);
        end
        hold   = out_valid && !out_ready;
        hold_y = out_y;
        if (out_valid && out_ready) begin
          if (sb_y.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got out_y=%0b with no vector pending", out_y);
          end else begin
            y = sb_y.pop_front();
            c = sb_c.pop_front();
            check1("out_y", out_y, y);
            if (lat_chk) checkn("latency", cyc - c, 2);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin : main
    int cur;

    cfgs[0] = '{16'h0691, 4'h0, 8'hE4, 1'b0, 1'b0};
    cfgs[1] = '{16'h0691, 4'h0, 8'hE4, 1'b1, 1'b0};
    cfgs[2] = '{16'h0691, 4'h1, 8'hE4, 1'b0, 1'b0};
    cfgs[3] = '{16'h0691, 4'h0, 8'hB4, 1'b0, 1'b0};
    cfgs[4] = '{16'h0691, 4'h0, 8'h00, 1'b0, 1'b1};
    cfgs[5] = '{16'h0691, 4'h0, 8'hE4, 1'b0, 1'b0};

    vecs[0]  = '{0, 4'd0,  1'b1};
    vecs[1]  = '{0, 4'd1,  1'b0};
    vecs[2]  = '{0, 4'd4,  1'b1};
    vecs[3]  = '{0, 4'd7,  1'b1};
    vecs[4]  = '{0, 4'd9,  1'b1};
    vecs[5]  = '{0, 4'd10, 1'b1};
    vecs[6]  = '{0, 4'd15, 1'b0};
    vecs[7]  = '{1, 4'd0,  1'b0};
    vecs[8]  = '{1, 4'd1,  1'b1};
    vecs[9]  = '{2, 4'd1,  1'b1};
    vecs[10] = '{2, 4'd0,  1'b0};
    vecs[11] = '{3, 4'd4,  1'b0};
    vecs[12] = '{3, 4'd8,  1'b1};
    vecs[13] = '{4, 4'd4,  1'b0};

    bp_x = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd9, 4'd10, 4'd15, 4'd3};
    bp_y = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  1'b0,  1'b0};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_x        = '0;
    out_ready   = 1'b1;
    cfg_valid   = 1'b0;
    cfg_tt      = '0;
    cfg_neg_in  = '0;
    cfg_perm    = '0;
    cfg_neg_out = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_y", out_y, 1'b0);
    check1("rst_cfg_ready", cfg_ready, 1'b0);
    check1("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Table: default config stream, then mid-stream config loads
    cur = 0;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].cfg_id != cur) begin
        cur = vecs[i].cfg_id;
        do_cfg(cfgs[cur]);
      end
      send(vecs[i].x, vecs[i].y, 1'b1);
    end
    wait_drain("drain_table");

    // Backpressure: continuous input, out_ready low for 3 cycles
    do_cfg(cfgs[5]);
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_x[i], bp_y[i], 1'b1);
      end
      begin
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check1("bp_output_started", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check1("bp_in_ready_low", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_bp");
    lat_chk = 1'b1;

    // Non-default config active before reset: in_x=0 -> 0
    do_cfg(cfgs[1]);
    send(4'd0, 1'b0, 1'b1);
    wait_drain("drain_pre_rst");

    // Reset during DRAIN with two vectors in flight
    out_ready = 1'b0;
    send(4'd0, 1'b0, 1'b0);
    send(4'd1, 1'b0, 1'b0);
    cfg_tt      = 16'h0691;
    cfg_neg_in  = 4'h0;
    cfg_perm    = 8'hE4;
    cfg_neg_out = 1'b0;
    cfg_valid   = 1'b1;
    @(negedge clk);
    check1("rst_seq_in_ready_blocked", in_ready, 1'b0);
    check1("rst_seq_full", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check1("async_rst_out_valid", out_valid, 1'b0);
    check1("async_rst_out_y", out_y, 1'b0);
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check1("no_stale_result", out_valid, 1'b0);
    end
    check1("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(4'd0, 1'b1, 1'b1);
    wait_drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
